// File: rtl/sha256_message_arbiter.sv
// sha256_message_arbiter: shares one sha256_message_build between NUM_REQ requesters, one packet per grant.
// Define SHA256_ARB_FIXED_PRIORITY_EN for fixed lowest-index-first arbitration instead of round-robin.
module sha256_message_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   sync_rst,
   input  logic [NUM_REQ*64-1:0]  req_cfg_size,
   input  logic [NUM_REQ*2-1:0]   req_cfg_scheme,
   input  logic [NUM_REQ-1:0]     req_cfg_last,
   input  logic [NUM_REQ-1:0]     req_cfg_valid,
   output logic [NUM_REQ-1:0]     req_cfg_ready,
   input  logic [NUM_REQ*512-1:0] req_data,
   input  logic [NUM_REQ-1:0]     req_data_last,
   input  logic [NUM_REQ-1:0]     req_data_valid,
   output logic [NUM_REQ-1:0]     req_data_ready,
   output logic [63:0]            cfg_size,
   output logic [1:0]             cfg_scheme,
   output logic                   cfg_last,
   output logic                   cfg_valid,
   input  logic                   cfg_ready,
   output logic [511:0]           data_out,
   output logic                   data_out_last,
   output logic                   data_out_valid,
   input  logic                   data_out_ready,
   output logic [ID_W-1:0]        grant_id,
   output logic                   busy
);
   typedef enum logic [1:0] {IDLE, CFG, DATA} state_t;
   state_t state_q, state_d;
   logic [ID_W-1:0] grant_id_q, grant_id_d, win, cand;
   logic hit;
   logic [63:0] sel_size;
   logic [1:0] sel_scheme;
   logic [511:0] sel_data;
   logic sel_cfg_last, sel_cfg_valid, sel_data_last, sel_data_valid;
`ifndef SHA256_ARB_FIXED_PRIORITY_EN
   logic [ID_W-1:0] last_grant_q, last_grant_d;
`endif

   // Descending scan so the candidate closest to the search start is assigned last and wins
   always_comb begin
      hit  = 1'b0;
      win  = '0;
      cand = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
`ifdef SHA256_ARB_FIXED_PRIORITY_EN
         cand = ID_W'(k);
`else
         cand = ID_W'((int'(last_grant_q) + 1 + k) % NUM_REQ);
`endif
         if (req_cfg_valid[cand]) begin
            hit = 1'b1;
            win = cand;
         end
      end
   end

   always_comb begin
      sel_size       = '0;
      sel_scheme     = '0;
      sel_cfg_last   = 1'b0;
      sel_cfg_valid  = 1'b0;
      sel_data       = '0;
      sel_data_last  = 1'b0;
      sel_data_valid = 1'b0;
      for (int i = 0; i < NUM_REQ; i++)
         if (grant_id_q == ID_W'(i)) begin
            sel_size       = req_cfg_size[i*64 +: 64];
            sel_scheme     = req_cfg_scheme[i*2 +: 2];
            sel_cfg_last   = req_cfg_last[i];
            sel_cfg_valid  = req_cfg_valid[i];
            sel_data       = req_data[i*512 +: 512];
            sel_data_last  = req_data_last[i];
            sel_data_valid = req_data_valid[i];
         end
   end

   always_comb begin
      cfg_valid      = en && state_q == CFG && sel_cfg_valid;
      cfg_size       = state_q == CFG ? sel_size : '0;
      cfg_scheme     = state_q == CFG ? sel_scheme : '0;
      cfg_last       = state_q == CFG && sel_cfg_last;
      data_out_valid = en && state_q == DATA && sel_data_valid;
      data_out       = state_q == DATA ? sel_data : '0;
      data_out_last  = state_q == DATA && sel_data_last;
      req_cfg_ready  = '0;
      req_data_ready = '0;
      req_cfg_ready[grant_id_q]  = en && state_q == CFG && cfg_ready;
      req_data_ready[grant_id_q] = en && state_q == DATA && data_out_ready;
      grant_id = grant_id_q;
      busy     = state_q != IDLE;
   end

   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
`ifndef SHA256_ARB_FIXED_PRIORITY_EN
      last_grant_d = last_grant_q;
`endif
      if (sync_rst) begin
         state_d    = IDLE;
         grant_id_d = '0;
`ifndef SHA256_ARB_FIXED_PRIORITY_EN
         last_grant_d = ID_W'(NUM_REQ - 1);
`endif
      end else if (en) begin
         if (state_q == IDLE && hit) begin
            state_d    = CFG;
            grant_id_d = win;
         end
         if (cfg_valid && cfg_ready)
            state_d = DATA;
         if (data_out_valid && data_out_ready && data_out_last) begin
            state_d = IDLE;
`ifndef SHA256_ARB_FIXED_PRIORITY_EN
            last_grant_d = grant_id_q;
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q    <= IDLE;
         grant_id_q <= '0;
`ifndef SHA256_ARB_FIXED_PRIORITY_EN
         last_grant_q <= ID_W'(NUM_REQ - 1);
`endif
      end else begin
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
`ifndef SHA256_ARB_FIXED_PRIORITY_EN
         last_grant_q <= last_grant_d;
`endif
      end
endmodule

// File: tb/tb_sha256_message_arbiter.sv
// tb_sha256_message_arbiter: randomized requesters and builder handshakes checked against a packet-level arbitration model.
module tb_sha256_message_arbiter;
   localparam int N  = 2;
   localparam int IW = 1;

   logic clk = 1'b0;
   logic rst, en, sync_rst;
   logic [N*64-1:0] req_cfg_size;
   logic [N*2-1:0] req_cfg_scheme;
   logic [N-1:0] req_cfg_last, req_cfg_valid, req_cfg_ready;
   logic [N*512-1:0] req_data;
   logic [N-1:0] req_data_last, req_data_valid, req_data_ready;
   logic [63:0] cfg_size;
   logic [1:0] cfg_scheme;
   logic cfg_last, cfg_valid, cfg_ready;
   logic [511:0] data_out;
   logic data_out_last, data_out_valid, data_out_ready;
   logic [IW-1:0] grant_id;
   logic busy;

   always #5 clk = ~clk;

   sha256_message_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
      .clk(clk), .rst(rst), .en(en), .sync_rst(sync_rst),
      .req_cfg_size(req_cfg_size), .req_cfg_scheme(req_cfg_scheme), .req_cfg_last(req_cfg_last),
      .req_cfg_valid(req_cfg_valid), .req_cfg_ready(req_cfg_ready),
      .req_data(req_data), .req_data_last(req_data_last), .req_data_valid(req_data_valid),
      .req_data_ready(req_data_ready),
      .cfg_size(cfg_size), .cfg_scheme(cfg_scheme), .cfg_last(cfg_last), .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .data_out(data_out), .data_out_last(data_out_last), .data_out_valid(data_out_valid),
      .data_out_ready(data_out_ready),
      .grant_id(grant_id), .busy(busy)
   );

   int total = 0, bad = 0;
   logic [66:0] cur_cfg [N];
   logic [66:0] exp_cfg [N];
   logic [512:0] drv_q [N][$];
   logic [512:0] exp_q [N][$];
   bit cfg_pend [N];
   bit dv [N];
   int cfg_dly [N], nxt_dly [N], nb_fix [N], pkts_left [N];
   logic [N-1:0] hs_c, hs_d;
   bit clr, gapless, fix_cfg, tog;
   int rdy_mode, ph, own, lastg, n_dhs;
   int order [$];
   int exp_ord [4];
   int k0, n;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [511:0] rnd512();
      logic [511:0] v;
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Winner of an IDLE cycle: first requesting index after the previous owner, wrapping
   function automatic int pick();
`ifdef SHA256_ARB_FIXED_PRIORITY_EN
      for (int k = 0; k < N; k++) if (req_cfg_valid[k]) return k;
`else
      for (int k = 1; k <= N; k++) if (req_cfg_valid[(lastg + k) % N]) return (lastg + k) % N;
`endif
      return 0;
   endfunction

   function automatic bit pend();
      for (int r = 0; r < N; r++) if (pkts_left[r] > 0 || drv_q[r].size() > 0 || cfg_pend[r]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic load(input int r);
      int nb;
      logic [512:0] beat;
      nb = nb_fix[r] > 0 ? nb_fix[r] : int'($urandom_range(4, 1));
      cur_cfg[r] = fix_cfg ? {64'd24, 2'd0, 1'b1} : {$urandom, $urandom, 2'($urandom), 1'($urandom)};
      exp_cfg[r] = cur_cfg[r];
      for (int b = 0; b < nb; b++) begin
         beat = {b == nb - 1, rnd512()};
         drv_q[r].push_back(beat);
         exp_q[r].push_back(beat);
      end
      cfg_pend[r] = 1'b1;
      cfg_dly[r] = nxt_dly[r];
      pkts_left[r]--;
   endtask

   task automatic drive();
      logic [512:0] discard;
      for (int r = 0; r < N; r++) begin
         if (clr) begin
            drv_q[r].delete();
            cfg_pend[r] = 1'b0;
            dv[r] = 1'b0;
         end else begin
            if (hs_c[r]) cfg_pend[r] = 1'b0;
            if (hs_d[r] && drv_q[r].size() > 0) discard = drv_q[r].pop_front();
         end
         if (!cfg_pend[r] && drv_q[r].size() == 0 && pkts_left[r] > 0) load(r);
         else if (cfg_dly[r] > 0) cfg_dly[r]--;
         dv[r] = drv_q[r].size() == 0 ? 1'b0 : gapless ? 1'b1 :
                 (dv[r] && !hs_d[r] && !clr) ? 1'b1 : ($urandom_range(3, 0) != 0);
         req_cfg_valid[r] = cfg_pend[r] && cfg_dly[r] == 0;
         {req_cfg_size[r*64 +: 64], req_cfg_scheme[r*2 +: 2], req_cfg_last[r]} = cur_cfg[r];
         req_data_valid[r] = dv[r];
         {req_data_last[r], req_data[r*512 +: 512]} = drv_q[r].size() > 0 ? drv_q[r][0] : '0;
      end
      clr = 1'b0;
      hs_c = '0;
      hs_d = '0;
      tog = !tog;
      cfg_ready = rdy_mode == 0 ? 1'($urandom_range(1, 0)) : 1'b1;
      data_out_ready = rdy_mode == 0 ? 1'($urandom_range(1, 0)) : rdy_mode == 2 ? tog : 1'b1;
   endtask

   task automatic model();
      logic [N-1:0] xc, xd;
      logic [512:0] e;
      int nph;
      hs_c = req_cfg_valid & req_cfg_ready;
      hs_d = req_data_valid & req_data_ready;
      if (rst) begin
         check("rst_out", 512'({busy, cfg_valid, data_out_valid, req_cfg_ready, req_data_ready}), '0);
         check("rst_gid", 512'(grant_id), '0);
         ph = 0; own = 0; lastg = N - 1; clr = 1'b1;
         for (int r = 0; r < N; r++) exp_q[r].delete();
         return;
      end
      xc = '0;
      xd = '0;
      if (en && ph == 1) xc[own] = cfg_ready;
      if (en && ph == 2) xd[own] = data_out_ready;
      nph = ph;
      check("busy", 512'(busy), 512'(ph != 0));
      check("gid", 512'(grant_id), 512'(own));
      check("cfg_rdy", 512'(req_cfg_ready), 512'(xc));
      check("dat_rdy", 512'(req_data_ready), 512'(xd));
      check("cfg_vld", 512'(cfg_valid), 512'(en && ph == 1 && req_cfg_valid[own]));
      check("dat_vld", 512'(data_out_valid), 512'(en && ph == 2 && req_data_valid[own]));
      if (ph == 0) begin
         check("idle_cfg", 512'({cfg_size, cfg_scheme, cfg_last, data_out_last}), '0);
         check("idle_dat", data_out, '0);
         if (en && req_cfg_valid != '0) begin
            own = pick();
            order.push_back(own);
            nph = 1;
         end
      end
      if (ph == 1 && cfg_valid && cfg_ready) begin
         check("cfg_pay", 512'({cfg_size, cfg_scheme, cfg_last}), 512'(exp_cfg[own]));
         nph = 2;
      end
      if (ph == 2 && data_out_valid && data_out_ready) begin
         if (exp_q[own].size() > 0) e = exp_q[own].pop_front();
         else e = '1;
         check("dat_pay", data_out, e[511:0]);
         check("dat_last", 512'(data_out_last), 512'(e[512]));
         n_dhs++;
         if (e[512]) begin
            nph = 0;
            lastg = own;
         end
      end
      if (sync_rst) begin
         nph = 0; own = 0; lastg = N - 1; clr = 1'b1;
         for (int r = 0; r < N; r++) exp_q[r].delete();
      end
      ph = nph;
   endtask

   task automatic cyc();
      @(negedge clk);
      model();
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic finish_all(input int budget);
      int c = 0;
      while ((ph != 0 || pend()) && c < budget) begin
         cyc();
         c++;
      end
      check("timeout", 512'(c >= budget), '0);
   endtask

   task automatic do_sync();
      sync_rst = 1'b1;
      cyc();
      sync_rst = 1'b0;
      check("sr_gid", 512'(grant_id), '0);
      check("sr_busy", 512'(busy), '0);
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; sync_rst = 1'b0;
      req_cfg_size = '0; req_cfg_scheme = '0; req_cfg_last = '0; req_cfg_valid = '0;
      req_data = '0; req_data_last = '0; req_data_valid = '0;
      cfg_ready = 1'b0; data_out_ready = 1'b0;
      hs_c = '0; hs_d = '0; clr = 1'b0; tog = 1'b0;
      ph = 0; own = 0; lastg = N - 1; n_dhs = 0;
      for (int r = 0; r < N; r++) begin
         cur_cfg[r] = '0; exp_cfg[r] = '0; cfg_pend[r] = 1'b0; dv[r] = 1'b0;
         cfg_dly[r] = 0; nxt_dly[r] = 0; nb_fix[r] = 0; pkts_left[r] = 0;
      end
      rdy_mode = 1; gapless = 1'b1; fix_cfg = 1'b0;
      cyc(); cyc();
      rst = 1'b0;
      cyc();

      // single requester, single-beat packet
      fix_cfg = 1'b1; nb_fix[0] = 1; pkts_left[0] = 1;
      cyc();
      cyc();
      check("t1_cfgv", 512'(cfg_valid), 512'(1));
      check("t1_gid", 512'(grant_id), '0);
      finish_all(100);
      check("t1_dhs", 512'(n_dhs), 512'(1));
      fix_cfg = 1'b0;

      // contention, 2 packets of 2 beats each
      do_sync();
      order.delete();
      nb_fix[0] = 2; nb_fix[1] = 2; pkts_left[0] = 2; pkts_left[1] = 2;
      finish_all(200);
`ifdef SHA256_ARB_FIXED_PRIORITY_EN
      exp_ord = '{0, 0, 1, 1};
`else
      exp_ord = '{0, 1, 0, 1};
`endif
      check("t2_cnt", 512'(order.size()), 512'(4));
      for (int i = 0; i < 4 && i < order.size(); i++) check("t2_ord", 512'(order[i]), 512'(exp_ord[i]));
      do_sync();

      // backpressure: toggling data_out_ready on a 3-beat packet
      rdy_mode = 2; tog = 1'b0; nb_fix[1] = 3; pkts_left[1] = 1; k0 = n_dhs;
      finish_all(100);
      check("t3_dhs", 512'(n_dhs - k0), 512'(3));
      rdy_mode = 1;

      // data offered 5 cycles ahead of cfg
      nxt_dly[1] = 5; nb_fix[1] = 2; pkts_left[1] = 1; k0 = n_dhs;
      cyc();
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("t4_rdy", 512'(req_data_ready[1]), '0);
         check("t4_fwd", 512'(data_out_valid), '0);
      end
      finish_all(100);
      check("t4_dhs", 512'(n_dhs - k0), 512'(2));
      nxt_dly[1] = 0;

      // async reset after beat 1 of 3 from requester 1
      nb_fix[1] = 3; pkts_left[1] = 1; k0 = n_dhs; n = 0;
      while (n_dhs == k0 && n < 50) begin cyc(); n++; end
      check("t5_beat", 512'(n_dhs - k0), 512'(1));
      check("t5_gid0", 512'(grant_id), 512'(1));
      rst = 1'b1;
      #1;
      check("t5_rst", 512'({busy, cfg_valid, data_out_valid, req_cfg_ready, req_data_ready}), '0);
      check("t5_gid", 512'(grant_id), '0);
      cyc();
      rst = 1'b0;
      order.delete();
      nb_fix[0] = 1; nb_fix[1] = 1; pkts_left[0] = 1; pkts_left[1] = 1;
      finish_all(100);
      check("t5_cnt", 512'(order.size()), 512'(2));
      if (order.size() > 0) check("t5_first", 512'(order[0]), '0);

      // en low for 4 cycles mid-packet
      nb_fix[0] = 4; pkts_left[0] = 1; k0 = n_dhs; n = 0;
      while (n_dhs == k0 && n < 50) begin cyc(); n++; end
      en = 1'b0;
      for (int i = 0; i < 4; i++) cyc();
      check("t6_hold", 512'(n_dhs - k0), 512'(1));
      check("t6_gid", 512'(grant_id), '0);
      check("t6_busy", 512'(busy), 512'(1));
      en = 1'b1;
      finish_all(100);
      check("t6_dhs", 512'(n_dhs - k0), 512'(4));

      // randomized traffic
      rdy_mode = 0; gapless = 1'b0; nb_fix[0] = 0; nb_fix[1] = 0;
      pkts_left[0] = 40; pkts_left[1] = 40;
      for (int i = 0; i < 1500; i++) begin
         en = $urandom_range(7, 0) != 0;
         sync_rst = $urandom_range(199, 0) == 0;
         for (int r = 0; r < N; r++) nxt_dly[r] = int'($urandom_range(3, 0));
         cyc();
      end
      sync_rst = 1'b0; en = 1'b1;
      finish_all(3000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sha256_message_arbiter.md
Name: sha256_message_arbiter

Overview:
Shares one sha256_message_build instance between NUM_REQ requesters. Each requester presents a cfg stream and a 512-bit data stream. The arbiter grants one requester for a whole packet: one cfg beat, then data beats up to and including data_last. Granted channels are forwarded combinationally, and grant_id tags the owner for downstream hash-result routing.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ID_W, 1, width of grant_id; must equal clog2(NUM_REQ), minimum 1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
en  in  1  block enable; 0 freezes state and blocks all handshakes
sync_rst  in  1  synchronous reset, same effect as rst at the next edge
req_cfg_size  in  NUM_REQ*64  per-requester message size in bits; requester i uses slice [i*64 +: 64]
req_cfg_scheme  in  NUM_REQ*2  per-requester scheme
req_cfg_last  in  NUM_REQ  per-requester cfg last flag
req_cfg_valid  in  NUM_REQ  per-requester cfg valid
req_cfg_ready  out  NUM_REQ  per-requester cfg ready
req_data  in  NUM_REQ*512  per-requester data block
req_data_last  in  NUM_REQ  last block of packet
req_data_valid  in  NUM_REQ  data valid
req_data_ready  out  NUM_REQ  data ready
cfg_size  out  64  to builder
cfg_scheme  out  2  to builder
cfg_last  out  1  to builder
cfg_valid  out  1  to builder
cfg_ready  in  1  from builder
data_out  out  512  to builder data_in
data_out_last  out  1  to builder data_in_last
data_out_valid  out  1  to builder data_in_valid
data_out_ready  in  1  from builder data_in_ready
grant_id  out  ID_W  index of the current owner
busy  out  1  1 when state is not IDLE

Behaviour:
- FSM states: IDLE, CFG, DATA.
- Registers: state, grant_id, last_grant.
- Reset, from rst or from sync_rst at a clock edge:
  - state=IDLE, grant_id=0, last_grant=NUM_REQ-1, so requester 0 has first priority.
  - Every output valid/ready is 0 and busy=0.
  - All outputs are decoded from state, so reset mid-packet abandons the packet immediately. Requesters must restart the packet.
- IDLE:
  - All readies are 0. Output valids are 0 and output data/cfg buses are 0.
  - Arbitration is round-robin over req_cfg_valid, searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - On any hit: grant_id<=winner, state<=CFG.
  - Grant latency is 1 cycle from req_cfg_valid to cfg_valid.
  - req_data_valid alone never wins arbitration.
- CFG:
  - cfg_* outputs = granted slice; cfg_valid = req_cfg_valid[grant_id].
  - req_cfg_ready[grant_id] = cfg_ready; all other readies are 0. Data readies are all 0.
  - On cfg handshake: state<=DATA.
- DATA:
  - data_out / data_out_last = granted slice; data_out_valid = req_data_valid[grant_id].
  - req_data_ready[grant_id] = data_out_ready.
  - On handshake with data_last=1: state<=IDLE, last_grant<=grant_id.
  - A single-beat packet (last on the first beat) is legal.
- Throughput: forwarding is zero-latency, so back-to-back beats run at 1 per cycle. Between packets there is exactly 1 IDLE cycle.
- en=0:
  - All state is held.
  - All ready outputs and cfg_valid/data_out_valid are forced to 0; no handshake can occur.
  - grant_id and busy keep their values.
- Requesters must hold valid and payload stable until ready. The arbiter does not check this.
- A new request arriving during a packet waits; it is not preempted.

Optional Feature:
SHA256_ARB_FIXED_PRIORITY_EN
- Defined: arbitration in IDLE is fixed priority, lowest asserted index wins. last_grant is not implemented.
- Undefined: round-robin as specified above.
- All other behaviour is identical in both builds.

Test Plan:
1. Single requester: req 0 sends cfg (size=64'd24, scheme=0, last=1), then 1 data beat with last=1. Expect cfg_valid 1 cycle after req_cfg_valid[0], grant_id=0, data_out equal to the input block, busy returning to 0 one cycle after the last handshake.
2. Contention: both requesters assert cfg_valid at the same edge, each with 2 data beats.
   - Default build: grant order is 0,1,0,1 over 4 packets.
   - SHA256_ARB_FIXED_PRIORITY_EN build: order is 0,0,... while req 0 keeps requesting.
   - No beat interleaving in either build.
3. Backpressure: data_out_ready toggles 1,0,1,0 during a 3-beat packet. Expect req_data_ready[grant] to mirror data_out_ready exactly, 3 handshakes, and other-requester readies held at 0 throughout.
4. Data before cfg: req 1 asserts data_valid 5 cycles before cfg_valid. Expect req_data_ready[1]=0 until the cfg handshake completes; no beat is forwarded early.
5. Reset mid-packet: assert rst after beat 1 of 3. Expect all valids/readies at 0 immediately, state IDLE, grant_id=0, and a clean re-arbitration with requester 0 first.
6. en=0 for 4 cycles mid-DATA: expect no handshakes and grant_id/busy held. After en=1, the remaining beats complete in order.
